fp_cmp_arb: RTL

- Round-robin arbiter and sequencer that shares one fp_cmp instance (feq/flt/fle) between NREQ independent requesters, e.g. several issue lanes or a vector unit.
- Accepts one compare at a time through per-requester valid/ready handshakes.
- Registers the operands, evaluates them in the shared comparator, and returns result/flags to the owning requester through a held response handshake.

---
 rtl/fp_wire.sv | 38 +++
 rtl/fp_cmp.sv | 47 ++++
 rtl/fp_rr_arb.sv | 33 +++
 rtl/fp_cmp_arb.sv | 118 +++++++++++
 4 files changed

// File: rtl/fp_wire.sv
// Shared floating-point wire types: comparator bundles and the
// state/register types of the shared-comparator arbiter.
package fp_wire;

  localparam int FP_ARB_IDW_MAX = 3;

  typedef struct packed {
    logic [64:0] data1;
    logic [64:0] data2;
    logic [9:0]  class1;
    logic [9:0]  class2;
    logic [2:0]  rm;
  } fp_cmp_in_type;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  flags;
  } fp_cmp_out_type;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } fp_cmp_arb_state_type;

  typedef struct packed {
    logic [64:0]               data1;
    logic [64:0]               data2;
    logic [9:0]                class1;
    logic [9:0]                class2;
    logic [2:0]                rm;
    logic [FP_ARB_IDW_MAX-1:0] id;
    logic [63:0]               result;
    logic [4:0]                flags;
    logic                      valid;
  } fp_cmp_arb_reg_type;

endpackage

// File: rtl/fp_cmp.sv
// Combinational feq/flt/fle on sign-magnitude operands.
// rm: 0 = fle, 1 = flt, 2 = feq, others produce zero.
module fp_cmp
  import fp_wire::*;
(
  input  fp_cmp_in_type  fp_cmp_i,
  output fp_cmp_out_type fp_cmp_o
);

  logic nan;
  logic snan;
  logic zero;
  logic eq;
  logic lt;

  always_comb begin
    nan  = fp_cmp_i.class1[8] | fp_cmp_i.class1[9] |
           fp_cmp_i.class2[8] | fp_cmp_i.class2[9];
    snan = fp_cmp_i.class1[8] | fp_cmp_i.class2[8];
    zero = (|fp_cmp_i.class1[4:3]) & (|fp_cmp_i.class2[4:3]);
    eq   = zero | (fp_cmp_i.data1 == fp_cmp_i.data2);
    // +0 and -0 compare equal, so a sign mismatch of zeros is not lt
    if (fp_cmp_i.data1[64] != fp_cmp_i.data2[64])
      lt = fp_cmp_i.data1[64] & ~zero;
    else if (fp_cmp_i.data1[64])
      lt = fp_cmp_i.data1[63:0] > fp_cmp_i.data2[63:0];
    else
      lt = fp_cmp_i.data1[63:0] < fp_cmp_i.data2[63:0];
    fp_cmp_o = '0;
    unique case (1'b1)
      (fp_cmp_i.rm == 3'd0): begin
        if (nan) fp_cmp_o.flags[4] = 1'b1;
        else fp_cmp_o.result[0] = lt | eq;
      end
      (fp_cmp_i.rm == 3'd1): begin
        if (nan) fp_cmp_o.flags[4] = 1'b1;
        else fp_cmp_o.result[0] = lt;
      end
      (fp_cmp_i.rm == 3'd2): begin
        if (snan) fp_cmp_o.flags[4] = 1'b1;
        else if (!nan) fp_cmp_o.result[0] = eq;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_rr_arb.sv
// Combinational round-robin pick: first set request above ptr,
// wrapping at NREQ; returns one-hot grant and its index.
module fp_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    // walk farthest-first so the nearest hit overwrites last
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_cmp_arb.sv
// Round-robin sequencer sharing one fp_cmp between NREQ requesters.
// FP_CMP_ARB_FAST_EN: grant the next request in the RESP handoff cycle.
module fp_cmp_arb
  import fp_wire::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*65-1:0] req_data1,
  input  logic [NREQ*65-1:0] req_data2,
  input  logic [NREQ*10-1:0] req_class1,
  input  logic [NREQ*10-1:0] req_class2,
  input  logic [NREQ*3-1:0] req_rm,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
  output logic [63:0]       resp_result,
  output logic [4:0]        resp_flags,
  output logic [IDW-1:0]    resp_id,
  output logic              busy
);

`ifdef FP_CMP_ARB_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  fp_cmp_arb_state_type state;
  fp_cmp_arb_state_type state_n;
  fp_cmp_arb_reg_type   r;
  logic [IDW-1:0]       rr_ptr;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gidx;
  logic                 gany;
  logic                 ack;
  logic                 grant_en;
  logic                 take;
  fp_cmp_in_type        cmp_i;
  fp_cmp_out_type       cmp_o;

  fp_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gidx),
    .any(gany)
  );

  assign cmp_i.data1  = r.data1;
  assign cmp_i.data2  = r.data2;
  assign cmp_i.class1 = r.class1;
  assign cmp_i.class2 = r.class2;
  assign cmp_i.rm     = r.rm;

  fp_cmp u_cmp (
    .fp_cmp_i(cmp_i),
    .fp_cmp_o(cmp_o)
  );

  assign ack = (state == RESP) & resp_ready[r.id[IDW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (gany) state_n = EXEC;
      EXEC: state_n = RESP;
      RESP: if (ack) state_n = (FAST && gany) ? EXEC : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    grant_en  = (state == IDLE) | (FAST & ack);
    take      = grant_en & gany & ~reset;
    req_ready = take ? gnt : '0;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r      <= '0;
      rr_ptr <= IDW'(NREQ - 1);
    end else begin
      if (state == EXEC) begin
        r.result <= cmp_o.result;
        r.flags  <= cmp_o.flags;
        r.valid  <= 1'b1;
      end
      if (ack) r.valid <= 1'b0;
      if (take) begin
        r.data1  <= req_data1[65*gidx +: 65];
        r.data2  <= req_data2[65*gidx +: 65];
        r.class1 <= req_class1[10*gidx +: 10];
        r.class2 <= req_class2[10*gidx +: 10];
        r.rm     <= req_rm[3*gidx +: 3];
        r.id     <= FP_ARB_IDW_MAX'(gidx);
        rr_ptr   <= gidx;
      end
    end
  end

  assign resp_valid  = r.valid ? (NREQ'(1) << r.id[IDW-1:0]) : '0;
  assign resp_result = r.result;
  assign resp_flags  = r.flags;
  assign resp_id     = r.id[IDW-1:0];

endmodule
